// File: rtl/tmnt_audio_pkg.sv
// Shared widths, saturation limits and the volume encoding for the
// TMNT/MIA audio output stage.
package tmnt_audio_pkg;

  localparam int AUD_W   = 16;
  localparam int ACC_W   = 24;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {
    VOL_HALF = 2'd0,
    VOL_1    = 2'd1,
    VOL_2    = 2'd2,
    VOL_4    = 2'd3
  } vol_e;

endpackage

// File: rtl/tmnt_audio_onepole.sv
// One-pole low-pass accumulator: acc += (din - acc) >>> SHIFT.
// The arithmetic shift rounds toward minus infinity. The accumulator
// only moves when ce is high and is cleared by the synchronous reset.
module tmnt_audio_onepole #(
  parameter int ACC_W = 24,
  parameter int SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic signed [ACC_W-1:0] din,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] diff;
  logic signed [ACC_W-1:0] step;

  // Fractional step toward the new input.
  always_comb begin
    diff = din - acc;
    step = diff >>> SHIFT;
  end

  // Accumulator state, cleared on reset, advanced on ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (ce) begin
      acc <= acc + step;
    end
  end

endmodule

// File: rtl/tmnt_audio_out.sv
// TMNT/MIA audio output stage. It resamples the free-running mixdown
// every CLK_DIV clocks. Each sample then goes through a DC blocker, a
// one-pole low-pass, volume scaling and saturation, and is presented as
// a registered stereo pair with a one-cycle strobe.
// Optional feature: define AUDIO_DCBLOCK_EN to build the DC blocker in
// stage 1; otherwise stage 1 is a plain register. Latency stays
// 4 cycles in both builds.
module tmnt_audio_out
  import tmnt_audio_pkg::*;
#(
  parameter int CLK_DIV   = 2000,
  parameter int LPF_SHIFT = 2,
  parameter int DCB_SHIFT = 9
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] mixdown,
  input  logic [1:0]  volume,
  input  logic        mute,
  input  logic        clip_clr,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        out_strobe,
  output logic        clip
);

  localparam logic [15:0] LAST_COUNT = 16'(CLK_DIV - 1);
  localparam logic signed [ACC_W+1:0] SAT_HI = (ACC_W + 2)'(SAT_MAX);
  localparam logic signed [ACC_W+1:0] SAT_LO = (ACC_W + 2)'(SAT_MIN);

  if (CLK_DIV < 8 || CLK_DIV > 65535 || LPF_SHIFT < 0 || LPF_SHIFT > 8 ||
      DCB_SHIFT < 1 || DCB_SHIFT > 16) begin : g_param_check
    $error("tmnt_audio_out: parameter out of range");
  end

  // Volume gain as an arithmetic shift. The result is widened by two
  // bits so that x4 cannot wrap before saturation.
  function automatic logic signed [ACC_W+1:0] scale_vol(
    input logic signed [ACC_W-1:0] a,
    input vol_e                    v
  );
    logic signed [ACC_W+1:0] w;
    w = {{2{a[ACC_W-1]}}, a};
    case (v)
      VOL_HALF: scale_vol = w >>> 1;
      VOL_2:    scale_vol = w <<< 1;
      VOL_4:    scale_vol = w <<< 2;
      default:  scale_vol = w;
    endcase
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W+1:0] v);
    sat_hit = (v > SAT_HI) || (v < SAT_LO);
  endfunction

  function automatic logic signed [AUD_W-1:0] sat_aud(input logic signed [ACC_W+1:0] v);
    if (v > SAT_HI) begin
      sat_aud = AUD_W'(SAT_MAX);
    end else if (v < SAT_LO) begin
      sat_aud = AUD_W'(SAT_MIN);
    end else begin
      sat_aud = v[AUD_W-1:0];
    end
  endfunction

  logic [15:0]             count;
  logic                    tick;
  logic                    vld_p0, vld_p1, vld_p2, vld_p3;
  logic signed [ACC_W-1:0] x0_p0;
  logic signed [ACC_W-1:0] y1_p1;
  logic signed [ACC_W-1:0] lpf_p2;
  logic signed [ACC_W+1:0] scaled_p2;
  logic                    clip_evt_p2;
  logic signed [AUD_W-1:0] sat_p3;

  assign tick = en && (count == LAST_COUNT);

  // Output-rate counter, frozen while en is low.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST_COUNT) ? 16'd0 : count + 16'd1;
    end
  end

  // Stage valid bits. In-flight samples drain even if en drops; reset discards them.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p0 <= tick;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // ---- S0: capture the mixdown on the tick, sign-extended to ACC_W ----
  // Input sample register.
  always_ff @(posedge clk_sys) begin
    if (tick) begin
      x0_p0 <= {{(ACC_W - AUD_W){mixdown[AUD_W-1]}}, mixdown};
    end
  end

  // ---- S1: DC blocker (or plain register) ----
`ifdef AUDIO_DCBLOCK_EN
  logic signed [ACC_W-1:0] x_prev;
  logic signed [ACC_W-1:0] y_prev;
  logic signed [ACC_W-1:0] dcb_y;

  // High-pass: y = x - x_prev + y_prev - y_prev/2^DCB_SHIFT.
  always_comb begin
    dcb_y = x0_p0 - x_prev + y_prev - (y_prev >>> DCB_SHIFT);
  end

  // DC-blocker history, part of the filter state cleared by reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      x_prev <= '0;
      y_prev <= '0;
    end else if (vld_p0) begin
      x_prev <= x0_p0;
      y_prev <= dcb_y;
    end
  end

  // Stage 1 output register.
  always_ff @(posedge clk_sys) begin
    if (vld_p0) begin
      y1_p1 <= dcb_y;
    end
  end
`else
  // Stage 1 output register (pass-through build).
  always_ff @(posedge clk_sys) begin
    if (vld_p0) begin
      y1_p1 <= x0_p0;
    end
  end
`endif

  // ---- S2: one-pole reconstruction low-pass ----
  tmnt_audio_onepole #(
    .ACC_W (ACC_W),
    .SHIFT (LPF_SHIFT)
  ) u_lpf (
    .clk   (clk_sys),
    .reset (reset),
    .ce    (vld_p1),
    .din   (y1_p1),
    .acc   (lpf_p2)
  );

  // ---- S3: volume scaling and saturation ----
  // Gain applied to the filtered value, with limit detection for the clip flag.
  always_comb begin
    scaled_p2   = scale_vol(lpf_p2, vol_e'(volume));
    clip_evt_p2 = vld_p2 && sat_hit(scaled_p2);
  end

  // Saturated sample register.
  always_ff @(posedge clk_sys) begin
    if (vld_p2) begin
      sat_p3 <= sat_aud(scaled_p2);
    end
  end

  // Sticky clip flag; a new clip event beats a simultaneous clear.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clip <= 1'b0;
    end else if (clip_evt_p2) begin
      clip <= 1'b1;
    end else if (clip_clr) begin
      clip <= 1'b0;
    end
  end

  // ---- Output: registered stereo pair plus one-cycle strobe ----
  // Mute forces zero here only, so the filters keep their settled state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      out_l      <= '0;
      out_r      <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= vld_p3;
      if (vld_p3) begin
        out_l <= mute ? '0 : sat_p3;
        out_r <= mute ? '0 : sat_p3;
      end
    end
  end

endmodule
